bsram_list_reader: RTL and testbench

- Walks a singly linked list stored in a Gowin DPB BSRAM (8-bit x 2048), using one read-only port.
- Node layout, ADDRESS_STEP_N = 3 bytes: [addr] payload byte, [addr+1] next pointer high bits (bits 2:0 used), [addr+2] next pointer low byte.
- Next address 0 is the NULL terminator.
- Streams payload bytes out on a valid/ready handshake, then reports node count and a loop-guard error.

---
 rtl/bsram_list_reader.sv | 126 ++++++++++++
 tb/tb_bsram_list_reader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bsram_list_reader.sv
// bsram_list_reader: walks a linked list in 8x2048 BSRAM and streams payload bytes over valid/ready.
// Define BSRAM_LIST_RD_CHECKSUM_EN to add the csum output (XOR of emitted payloads).
module bsram_list_reader #(
  parameter int          RD_LATENCY   = 2,
  parameter int          MAX_NODES    = 255,
  parameter logic [10:0] NULL_ADDRESS = 11'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] head_addr,
  output logic        ram_ce,
  output logic        ram_oce,
  output logic        ram_wre,
  output logic [10:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  node_cnt,
  output logic        err_loop
`ifdef BSRAM_LIST_RD_CHECKSUM_EN
  , output logic [7:0] csum
`endif
);
  typedef enum logic [2:0] {IDLE, RD_DATA, RD_NHI, RD_NLO, EMIT, FINISH} state_t;
  localparam logic [1:0] LAT = 2'(RD_LATENCY);
  localparam logic [7:0] MAXN = 8'(MAX_NODES);
  state_t      state_q;
  logic [10:0] cur_q, next_q, ram_addr_q;
  logic [1:0]  lat_q;
  logic [7:0]  o_data_q, node_cnt_q;
  logic        o_valid_q, busy_q, done_q, err_q;
  logic        lat_hit;
  assign lat_hit  = lat_q == LAT;
  assign ram_ce   = 1'b1;
  assign ram_oce  = 1'b1;
  assign ram_wre  = 1'b0;
  assign ram_addr = ram_addr_q;
  assign o_data   = o_data_q;
  assign o_valid  = o_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign node_cnt = node_cnt_q;
  assign err_loop = err_q;
  // The address for the next byte is registered together with the state change,
  // so every read starts in the first cycle of its RD_* state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      next_q     <= '0;
      ram_addr_q <= '0;
      lat_q      <= '0;
      o_data_q   <= '0;
      o_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      node_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          node_cnt_q <= '0;
          err_q      <= 1'b0;
          cur_q      <= head_addr;
          ram_addr_q <= head_addr;
          lat_q      <= '0;
          busy_q     <= head_addr != NULL_ADDRESS;
          state_q    <= head_addr == NULL_ADDRESS ? FINISH : RD_DATA;
        end
        RD_DATA: if (lat_hit) begin
          o_data_q   <= ram_dout;
          ram_addr_q <= cur_q + 11'd1;
          lat_q      <= '0;
          state_q    <= RD_NHI;
        end else lat_q <= lat_q + 2'd1;
        RD_NHI: if (lat_hit) begin
          next_q[10:8] <= ram_dout[2:0];
          ram_addr_q   <= cur_q + 11'd2;
          lat_q        <= '0;
          state_q      <= RD_NLO;
        end else lat_q <= lat_q + 2'd1;
        RD_NLO: if (lat_hit) begin
          next_q[7:0] <= ram_dout;
          lat_q       <= '0;
          o_valid_q   <= 1'b1;
          state_q     <= EMIT;
        end else lat_q <= lat_q + 2'd1;
        EMIT: if (o_ready) begin
          o_valid_q  <= 1'b0;
          node_cnt_q <= node_cnt_q + 8'd1;
          if (next_q == NULL_ADDRESS) begin
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else if (node_cnt_q + 8'd1 == MAXN) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            cur_q      <= next_q;
            ram_addr_q <= next_q;
            state_q    <= RD_DATA;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef BSRAM_LIST_RD_CHECKSUM_EN
  logic [7:0] csum_q;
  assign csum = csum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else if (state_q == IDLE && start) csum_q <= '0;
    else if (state_q == EMIT && o_ready) csum_q <= csum_q ^ o_data_q;
  end
`endif
endmodule

// File: tb/tb_bsram_list_reader.sv
// tb_bsram_list_reader: table-driven walks over a modelled BSRAM plus reset/backpressure sequences.
module tb_bsram_list_reader;
  localparam int L = 2;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, o_ready = 1'b0;
  logic [10:0] head_addr = '0, ram_addr;
  logic [7:0]  ram_dout, o_data, node_cnt;
  logic        ram_ce, ram_oce, ram_wre, o_valid, busy, done, err_loop;
`ifdef BSRAM_LIST_RD_CHECKSUM_EN
  logic [7:0]  csum;
`endif
  int passed = 0, total = 0;
  logic [7:0] mem [2048];
  logic [7:0] pipe [L];
  bsram_list_reader #(.RD_LATENCY(L), .MAX_NODES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .head_addr(head_addr),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .busy(busy), .done(done), .node_cnt(node_cnt), .err_loop(err_loop)
`ifdef BSRAM_LIST_RD_CHECKSUM_EN
    , .csum(csum)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dout = pipe[L-1];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  typedef struct {
    logic [10:0]       head;
    int                hold;
    int                poke;
    int                n;
    logic [3:0][7:0]   b;
    logic [7:0]        cnt;
    logic              err;
    int                done_at;
    logic              chk_tr;
    logic [2:0][10:0]  tr;
  } vec_t;
  vec_t v [7];
  task automatic walk(input vec_t t, input int idx);
    logic [7:0]  got [$];
    logic [10:0] tr [$];
    logic [7:0]  x, prev_d;
    int          cyc, done_at, wt, dn;
    logic        prev_v, prev_r, busy_seen;
    done_at = -1; wt = 0; dn = 0; prev_v = 0; prev_r = 0; busy_seen = 0; x = '0; prev_d = '0;
    @(negedge clk);
    start = 1'b1; head_addr = t.head; o_ready = t.hold == 0;
    for (cyc = 1; cyc < 300 && done_at < 0; cyc++) begin
      @(negedge clk);
      start = cyc == t.poke;
      if (cyc == t.poke) head_addr = 11'd30;
      if (cyc == 1 || ram_addr != tr[tr.size()-1]) tr.push_back(ram_addr);
      busy_seen |= busy;
      if (o_valid && prev_v && !prev_r) chk($sformatf("v%0d_hold", idx), o_data, prev_d);
      if (o_valid && (t.hold == 0 || wt >= t.hold)) begin
        o_ready = 1'b1; got.push_back(o_data); wt = 0;
      end else begin
        o_ready = t.hold == 0;
        if (o_valid) wt++;
      end
      prev_v = o_valid; prev_d = o_data; prev_r = o_ready;
      if (done) done_at = cyc;
    end
    chk($sformatf("v%0d_done_cycle", idx), done_at, t.done_at);
    chk($sformatf("v%0d_nbytes", idx), got.size(), t.n);
    for (int i = 0; i < t.n && i < got.size(); i++) begin
      chk($sformatf("v%0d_byte%0d", idx, i), got[i], t.b[i]);
      x ^= t.b[i];
    end
    chk($sformatf("v%0d_node_cnt", idx), node_cnt, t.cnt);
    chk($sformatf("v%0d_err_loop", idx), err_loop, t.err);
    chk($sformatf("v%0d_busy_seen", idx), busy_seen, t.n > 0);
    chk($sformatf("v%0d_busy_end", idx), busy, 0);
    if (t.chk_tr)
      for (int i = 0; i < 3; i++) chk($sformatf("v%0d_addr%0d", idx, i), tr.size() > i ? tr[i] : 11'h7ff, t.tr[i]);
`ifdef BSRAM_LIST_RD_CHECKSUM_EN
    chk($sformatf("v%0d_csum", idx), csum, x);
`endif
    start = 1'b0; o_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk($sformatf("v%0d_done_single", idx), dn, 0);
    chk($sformatf("v%0d_cnt_hold", idx), node_cnt, t.cnt);
  endtask
  initial begin
    int k, dn;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[3] = 8'hA1;  mem[4] = 8'h00;  mem[5] = 8'h06;
    mem[6] = 8'hB2;  mem[7] = 8'h00;  mem[8] = 8'h09;
    mem[9] = 8'hC3;  mem[10] = 8'h00; mem[11] = 8'h00;
    mem[30] = 8'h33; mem[31] = 8'h00; mem[32] = 8'h1E;
    mem[2046] = 8'h5A; mem[2047] = 8'hF8; mem[0] = 8'h09;
    mem[12'h709] = 8'hEE; mem[12'h70A] = 8'h00; mem[12'h70B] = 8'h00;
    v[0] = '{11'd3,    0, -1, 3, {8'h00, 8'hC3, 8'hB2, 8'hA1}, 8'd3, 1'b0, 32, 1'b1, {11'd5, 11'd4, 11'd3}};
    v[1] = '{11'd0,    0, -1, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 8'd0, 1'b0,  2, 1'b0, {11'd0, 11'd0, 11'd0}};
    v[2] = '{11'd3,    5, -1, 3, {8'h00, 8'hC3, 8'hB2, 8'hA1}, 8'd3, 1'b0, 47, 1'b0, {11'd0, 11'd0, 11'd0}};
    v[3] = '{11'd30,   0, -1, 4, {8'h33, 8'h33, 8'h33, 8'h33}, 8'd4, 1'b1, 42, 1'b0, {11'd0, 11'd0, 11'd0}};
    v[4] = '{11'd0,    0, -1, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 8'd0, 1'b0,  2, 1'b0, {11'd0, 11'd0, 11'd0}};
    v[5] = '{11'd2046, 0, -1, 2, {8'h00, 8'h00, 8'hC3, 8'h5A}, 8'd2, 1'b0, 22, 1'b1, {11'd0, 11'd2047, 11'd2046}};
    v[6] = '{11'd3,    0,  5, 3, {8'h00, 8'hC3, 8'hB2, 8'hA1}, 8'd3, 1'b0, 32, 1'b0, {11'd0, 11'd0, 11'd0}};
    #12;
    chk("rst_ram_ce", ram_ce, 1);
    chk("rst_ram_oce", ram_oce, 1);
    chk("rst_ram_wre", ram_wre, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_node_cnt", node_cnt, 0);
    chk("rst_err_loop", err_loop, 0);
`ifdef BSRAM_LIST_RD_CHECKSUM_EN
    chk("rst_csum", csum, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 7; i++) walk(v[i], i);
    // Reset while a byte is being offered must drop everything at once.
    @(negedge clk); start = 1'b1; head_addr = 11'd3; o_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!o_valid && k < 50) begin @(negedge clk); k++; end
    chk("rst_mid_emit_reached", o_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_o_valid", o_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_node_cnt", node_cnt, 0);
    dn = 0;
    repeat (2) begin @(negedge clk); if (done) dn++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (done || busy) dn++; end
    chk("rst_mid_no_done", dn, 0);
    walk(v[0], 7);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
